// File: rtl/tristate_bus_arbiter.sv
// Round-robin arbiter for four requesters sharing one tristate data bus.
// Grants are registered one-hot enables; every change of owner passes through one released (Z) cycle.
module tristate_bus_arbiter #(
    parameter int DW       = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      req,
    input  logic [4*DW-1:0] din,
    output logic [3:0]      gnt,
    output logic [1:0]      owner,
    output logic            busy,
    output wire  [DW-1:0]   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

    state_t     state_q;
    logic [3:0] gnt_q;
    logic [1:0] owner_q;
    logic [1:0] last_q;
    logic [3:0] hold_q;

    logic       pick_vld;
    logic [1:0] pick_idx;

    // Scan from the farthest offset down so the nearest requester after last_q wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = last_q;
        for (int k = 4; k >= 1; k--) begin
            if (req[last_q + 2'(k)]) begin
                pick_vld = 1'b1;
                pick_idx = last_q + 2'(k);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            owner_q <= 2'd0;
            hold_q  <= 4'd0;
            last_q  <= 2'd3;
        end else begin
            case (state_q)
                IDLE, TURN: begin
                    if (pick_vld) begin
                        state_q <= GRANT;
                        gnt_q   <= 4'b0001 << pick_idx;
                        owner_q <= pick_idx;
                        hold_q  <= 4'd1;
                    end else begin
                        state_q <= IDLE;
                        gnt_q   <= 4'b0000;
                        hold_q  <= 4'd0;
                    end
                end
                GRANT: begin
                    // Release on request drop or exhausted hold; the TURN cycle gives break-before-make.
                    if (!req[owner_q] || hold_q >= HOLD_MAX) begin
                        state_q <= TURN;
                        gnt_q   <= 4'b0000;
                        hold_q  <= 4'd0;
                        last_q  <= owner_q;
                    end else begin
                        hold_q  <= hold_q + 4'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= 4'b0000;
                    hold_q  <= 4'd0;
                end
            endcase
        end
    end

    assign gnt   = gnt_q;
    assign owner = owner_q;
    assign busy  = |gnt_q;

    for (genvar i = 0; i < 4; i++) begin : g_drv
        assign bus = gnt_q[i] ? din[i*DW +: DW] : {DW{1'bz}};
    end

endmodule
